// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM states,
// register-index defaults and the zero-register index.
package pipe_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int ZERO_REG       = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: flags a Decode source that
// matches a non-zero load destination in Execute.
module hazard_cmp
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  rs1_used_d,
  input  logic                  rs2_used_d,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  load_e,
  output logic                  hz
);

  logic rd_nz;
  logic m1;
  logic m2;

  assign rd_nz = rd_e != REG_ADDR_W'(ZERO_REG);
  assign m1    = rs1_used_d & (rd_e == rs1_d);
  assign m2    = rs2_used_d & (rd_e == rs2_d);
  assign hz    = load_e & rd_nz & (m1 | m2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Optional perf counters: define PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W      = DEF_REG_ADDR_W,
  parameter int LOAD_USE_STALLS = 1,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic                  rs1_used_d,
  input  logic                  rs2_used_d,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  load_e,
  input  logic                  branch_taken_e,
  input  logic                  dmem_req_m,
  input  logic                  dmem_ack_m,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_write,
  output logic                  mem_wb_write,
  output logic                  mem_timeout_err
`ifdef PIPE_HAZARD_PERF_EN
 ,output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  hz_state_e   state_q, state_d;
  hz_state_e   saved_q, saved_d;
  hz_state_e   cur;
  logic [2:0]  remain_q, remain_d;
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        hz;
  logic        mw;

  hazard_cmp #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_cmp (
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rs1_used_d (rs1_used_d),
    .rs2_used_d (rs2_used_d),
    .rd_e       (rd_e),
    .load_e     (load_e),
    .hz         (hz)
  );

  assign mw  = dmem_req_m & ~dmem_ack_m;
  assign cur = (state_q == MEM_WAIT) ? saved_q : state_q;

  // Priority: mem wait, branch flush, load-use, run.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    state_d      = cur;
    saved_d      = saved_q;
    remain_d     = remain_q;
    tmo_d        = '0;
    err_d        = err_q;
    if (mw) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      state_d      = MEM_WAIT;
      saved_d      = cur;
      tmo_d        = (tmo_q == 16'hFFFF) ? tmo_q
                                         : tmo_q + 16'd1;
      if ({16'd0, tmo_d} >= 32'(MEM_TIMEOUT))
        err_d = 1'b1;
    end else if (branch_taken_e) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = RUN;
      remain_d     = '0;
    end else if (cur == LU_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (remain_q <= 3'd1) begin
        remain_d = '0;
        state_d  = RUN;
      end else begin
        remain_d = remain_q - 3'd1;
      end
    end else if (hz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LOAD_USE_STALLS > 1) begin
        remain_d = 3'(LOAD_USE_STALLS - 1);
        state_d  = LU_STALL;
      end
    end
  end

  // Controller state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      saved_q  <= RUN;
      remain_q <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      remain_q <= remain_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  assign mem_timeout_err = err_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Perf counters: stalled-PC cycles and flush cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write)
        stall_q <= stall_q + 32'd1;
      if (if_id_flush)
        flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a 3-stall
// and a 1-stall instance share directed stimulus.
module tb_pipe_hazard_ctrl;

  // {pc, ifid_w, flush, bubble, exmem_w, memwb_w, err}
  localparam logic [6:0] RN = 7'b1100110;
  localparam logic [6:0] ST = 7'b0001110;
  localparam logic [6:0] FL = 7'b1111110;
  localparam logic [6:0] WT = 7'b0000000;
  localparam logic [6:0] ER = 7'b0000001;

  typedef struct {
    string       name;
    logic [6:0]  ea;
    logic [6:0]  eb;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_e = '0;
  logic       rs1_used_d = 0, rs2_used_d = 0;
  logic       load_e = 0, branch_taken_e = 0;
  logic       dmem_req_m = 0, dmem_ack_m = 0;

  logic       a_pc, a_ifw, a_fl, a_bub, a_exw, a_wbw, a_err;
  logic       b_pc, b_ifw, b_fl, b_bub, b_exw, b_wbw, b_err;
  logic [6:0] a_vec, b_vec;

  exp_t       q[$];
  int         checks = 0;
  int         fails  = 0;
  int         m_stall = 0;
  int         m_flush = 0;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_ADDR_W (5), .LOAD_USE_STALLS (3), .MEM_TIMEOUT (8)
  ) dut_a (
    .clk (clk), .rst_n (rst_n),
    .rs1_d (rs1_d), .rs2_d (rs2_d),
    .rs1_used_d (rs1_used_d), .rs2_used_d (rs2_used_d),
    .rd_e (rd_e), .load_e (load_e),
    .branch_taken_e (branch_taken_e),
    .dmem_req_m (dmem_req_m), .dmem_ack_m (dmem_ack_m),
    .pc_write (a_pc), .if_id_write (a_ifw),
    .if_id_flush (a_fl), .id_ex_bubble (a_bub),
    .ex_mem_write (a_exw), .mem_wb_write (a_wbw),
    .mem_timeout_err (a_err)
`ifdef PIPE_HAZARD_PERF_EN
   ,.stall_count (a_sc), .flush_count (a_fc)
`endif
  );

  pipe_hazard_ctrl #(
    .REG_ADDR_W (5), .LOAD_USE_STALLS (1), .MEM_TIMEOUT (8)
  ) dut_b (
    .clk (clk), .rst_n (rst_n),
    .rs1_d (rs1_d), .rs2_d (rs2_d),
    .rs1_used_d (rs1_used_d), .rs2_used_d (rs2_used_d),
    .rd_e (rd_e), .load_e (load_e),
    .branch_taken_e (branch_taken_e),
    .dmem_req_m (dmem_req_m), .dmem_ack_m (dmem_ack_m),
    .pc_write (b_pc), .if_id_write (b_ifw),
    .if_id_flush (b_fl), .id_ex_bubble (b_bub),
    .ex_mem_write (b_exw), .mem_wb_write (b_wbw),
    .mem_timeout_err (b_err)
`ifdef PIPE_HAZARD_PERF_EN
   ,.stall_count (b_sc), .flush_count (b_fc)
`endif
  );

  assign a_vec = {a_pc, a_ifw, a_fl, a_bub, a_exw, a_wbw, a_err};
  assign b_vec = {b_pc, b_ifw, b_fl, b_bub, b_exw, b_wbw, b_err};

  // Monitor: pop one expectation per presented cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (a_vec !== e.ea) begin
        fails++;
        $display("FAIL %s dutA got %b want %b",
                 e.name, a_vec, e.ea);
      end
      checks++;
      if (b_vec !== e.eb) begin
        fails++;
        $display("FAIL %s dutB got %b want %b",
                 e.name, b_vec, e.eb);
      end
`ifdef PIPE_HAZARD_PERF_EN
      checks++;
      if (a_sc !== e.sc || a_fc !== e.fc) begin
        fails++;
        $display("FAIL %s perfA got %0d/%0d want %0d/%0d",
                 e.name, a_sc, a_fc, e.sc, e.fc);
      end
`endif
    end
  end

  task automatic step(
    input string      nm,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic       u1, input logic u2,
    input logic [4:0] rd, input logic ld,
    input logic       br, input logic rq,
    input logic       ak,
    input logic [6:0] ea, input logic [6:0] eb
  );
    exp_t e;
    @(posedge clk); #1;
    rs1_d = r1; rs2_d = r2;
    rs1_used_d = u1; rs2_used_d = u2;
    rd_e = rd; load_e = ld;
    branch_taken_e = br;
    dmem_req_m = rq; dmem_ack_m = ak;
    e.name = nm; e.ea = ea; e.eb = eb;
    e.sc = 32'(m_stall); e.fc = 32'(m_flush);
    q.push_back(e);
    if (!ea[6]) m_stall++;
    if (ea[4])  m_flush++;
  endtask

  task automatic idle(input string nm,
                      input logic [6:0] ea,
                      input logic [6:0] eb);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    rs1_d = '0; rs2_d = '0; rd_e = '0;
    rs1_used_d = 0; rs2_used_d = 0; load_e = 0;
    branch_taken_e = 0; dmem_req_m = 0; dmem_ack_m = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_stall = 0;
    m_flush = 0;
  endtask

  initial begin
    do_reset();
    idle("reset_idle", RN, RN);
    step("lu_detect", 0, 5, 0, 1, 5, 1, 0, 0, 0, ST, ST);
    idle("lu_stall2", ST, RN);
    idle("lu_stall3", ST, RN);
    idle("lu_done", RN, RN);
    step("rd_zero", 0, 0, 0, 1, 0, 1, 0, 0, 0, RN, RN);
    step("rs2_unused", 0, 5, 0, 0, 5, 1, 0, 0, 0, RN, RN);
    step("rs1_hz", 5, 0, 1, 0, 5, 1, 0, 0, 0, ST, ST);
    step("br_flush", 0, 0, 0, 0, 0, 0, 1, 0, 0, FL, FL);
    idle("post_flush", RN, RN);
    step("lu_detect2", 0, 5, 0, 1, 5, 1, 0, 0, 0, ST, ST);
    for (int i = 0; i < 4; i++)
      step("mw_in_lu", 0, 0, 0, 0, 0, 0, 0, 1, 0, WT, WT);
    step("mw_ack", 0, 0, 0, 0, 0, 0, 0, 1, 1, ST, RN);
    idle("lu_last", ST, RN);
    idle("lu_end", RN, RN);
    for (int i = 0; i < 10; i++)
      step("tmo_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0,
           (i >= 8) ? (WT | ER) : WT,
           (i >= 8) ? (WT | ER) : WT);
    step("tmo_ack", 0, 0, 0, 0, 0, 0, 0, 1, 1,
         RN | ER, RN | ER);
    idle("err_sticky", RN | ER, RN | ER);
    do_reset();
    idle("reset_clr", RN, RN);
    @(posedge clk);
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and stall controller for the 5-stage RISC-V pipeline; successor to the single-cycle load-use detector. It issues per-stage write enables, bubbles and flushes from Decode/Execute/Memory stage information. Added over the old detector: multi-cycle load-use stalls (for slower data memory), data-memory handshake back-pressure with timeout detection, and taken-branch flush. It sits beside the pipeline registers and drives their enables; it holds no datapath state.

## Interface
Parameters:
- REG_ADDR_W, 5, register-index width
- LOAD_USE_STALLS, 1, stall cycles per load-use hazard; legal 1..7
- MEM_TIMEOUT, 255, max consecutive cycles in MEM_WAIT before the error flag sets; legal 1..65535

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- rs1_d, rs2_d  in  REG_ADDR_W  Decode source registers
- rs1_used_d, rs2_used_d  in  1  the Decode instruction actually reads rs1/rs2
- rd_e  in  REG_ADDR_W  Execute destination
- load_e  in  1  Execute instruction is a load (ResultSrc bit 0)
- branch_taken_e  in  1  Execute resolved a taken branch/jump
- dmem_req_m  in  1  Memory stage has an outstanding data access
- dmem_ack_m  in  1  data memory completes the access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID cleared to NOP
- id_ex_bubble  out  1  ID/EX control fields zeroed
- ex_mem_write, mem_wb_write  out  1  EX/MEM, MEM/WB enables
- mem_timeout_err  out  1  sticky timeout flag
- stall_count, flush_count  out  32  perf counters (PIPE_HAZARD_PERF_EN only)

## Operation
- Hazard: hz = load_e & (rd_e != 0) & ((rs1_used_d & rd_e==rs1_d) | (rs2_used_d & rd_e==rs2_d)).
- FSM states RUN, LU_STALL, MEM_WAIT; register remain (3 bits), tmo (16 bits).
- Priority each cycle: memory wait > branch flush > load-use stall > run.
- Memory wait (mw = dmem_req_m & ~dmem_ack_m): all enables (pc_write, if_id_write, ex_mem_write, mem_wb_write) 0; id_ex_bubble 0, flushes 0; remain frozen; state MEM_WAIT, tmo increments, saturating. tmo reaching MEM_TIMEOUT sets mem_timeout_err (cleared only by reset). Ack or req drop: tmo cleared, return to the state saved on entry.
- Branch flush (branch_taken_e, not mw): if_id_flush=1, id_ex_bubble=1, all enables 1; pending LU_STALL cancelled (remain=0, state RUN) since the dependent instruction is discarded.
- Load-use (RUN, hz, no branch, not mw): pc_write=0, if_id_write=0, id_ex_bubble=1 this cycle; if LOAD_USE_STALLS>1, remain<=LOAD_USE_STALLS-1, state LU_STALL.
- LU_STALL: same three outputs; remain decrements each non-mw cycle; remain==1 -> RUN next. hz is ignored in LU_STALL (load already past Execute).
- RUN, no event: all enables 1, bubble/flush 0.

## Timing
- Outputs combinational from state and current inputs; state updates on rising clk.
- Load-use: exactly LOAD_USE_STALLS consecutive stall cycles, first in the detection cycle, plus any interleaved MEM_WAIT cycles.
- Flush: single cycle, same cycle as branch_taken_e.
- Reset (rst_n=0 at edge): state RUN, remain 0, tmo 0, mem_timeout_err 0, counters 0. Reset mid-stall or mid-wait abandons it. With idle inputs after reset: pc_write, if_id_write, ex_mem_write, mem_wb_write = 1; others 0.

## Configuration
- PIPE_HAZARD_PERF_EN defined: stall_count increments on every cycle with pc_write=0; flush_count on every cycle with if_id_flush=1; both wrap at 2^32.
- Undefined: counters and ports absent; no other behaviour change.

## Structure
- Shared package pipe_pkg: hazard FSM state enum, REG_ADDR_W default, zero-register constant.
- One sub-module natural: hazard_cmp (combinational hz comparator), reusable by the forwarding unit.

## Test plan
- rd_e=5, load_e=1, rs2_d=5, rs2_used_d=1, LOAD_USE_STALLS=1 -> one cycle pc_write=0, id_ex_bubble=1, then RUN.
- Same with LOAD_USE_STALLS=3 -> exactly 3 stall cycles; rd_e=0 or rs2_used_d=0 -> no stall.
- LOAD_USE_STALLS=3, branch_taken_e in 2nd stall cycle -> if_id_flush=1, id_ex_bubble=1, next cycle RUN with all enables 1.
- dmem_req_m=1, ack low 4 cycles during LU_STALL remain=2 -> all enables 0 for 4 cycles, then 2 further stall cycles.
- MEM_TIMEOUT=8, ack withheld 10 cycles -> mem_timeout_err high from cycle 8, stays after ack; cleared only by rst_n=0.
- With PIPE_HAZARD_PERF_EN: 3-stall load-use + one flush -> stall_count=3, flush_count=1; reset -> both 0.
